// File: rtl/matrix_stream_loader.sv
// Ping-pong loader: assembles a valid/ready element stream into ROWS x COLS matrices.
// Define LOADER_COLMAJOR_EN to fill column-major instead of row-major.
module matrix_stream_loader #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ROWS  = 4,
  parameter int unsigned COLS  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic [WIDTH-1:0] out_matrix [0:ROWS-1][0:COLS-1],
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err_last
);

  localparam int unsigned RowW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned ColW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [RowW-1:0] RowMax = RowW'(ROWS - 1);
  localparam logic [ColW-1:0] ColMax = ColW'(COLS - 1);

  logic [WIDTH-1:0] bank_q [0:1][0:ROWS-1][0:COLS-1];
  logic [1:0]       full_q, full_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [RowW-1:0]  row_q, row_d;
  logic [ColW-1:0]  col_q, col_d;
  logic             err_q, err_d;
  logic             accept, rel, is_final;

  assign in_ready  = rst & ~full_q[wr_bank_q];
  assign out_valid = full_q[rd_bank_q];
  assign err_last  = err_q;
  assign accept    = in_valid & in_ready;
  assign rel       = out_valid & out_ready;
  assign is_final  = (row_q == RowMax) && (col_q == ColMax);

  always_comb begin
    out_matrix = bank_q[rd_bank_q];
  end

  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    row_d     = row_q;
    col_d     = col_q;
    err_d     = err_q;
    if (rel) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
    if (accept) begin
      // Element count defines the boundary; in_last is only cross-checked.
      if (in_last != is_final) err_d = 1'b1;
      if (is_final) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        row_d             = '0;
        col_d             = '0;
      end else begin
`ifdef LOADER_COLMAJOR_EN
        if (row_q == RowMax) begin
          row_d = '0;
          col_d = col_q + ColW'(1);
        end else begin
          row_d = row_q + RowW'(1);
        end
`else
        if (col_q == ColMax) begin
          col_d = '0;
          row_d = row_q + RowW'(1);
        end else begin
          col_d = col_q + ColW'(1);
        end
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      row_q     <= '0;
      col_q     <= '0;
      err_q     <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < int'(ROWS); r++) begin
          for (int c = 0; c < int'(COLS); c++) begin
            bank_q[b][r][c] <= '0;
          end
        end
      end
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      row_q     <= row_d;
      col_q     <= col_d;
      err_q     <= err_d;
      if (accept) bank_q[wr_bank_q][row_q][col_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Bench for matrix_stream_loader: directed steps then random traffic against a queue model.
module tb_matrix_stream_loader;
  localparam int W = 8;
  localparam int R = 4;
  localparam int C = 4;
  localparam int N = R * C;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_last = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready, out_valid, err_last;
  logic [W-1:0] out_matrix [0:R-1][0:C-1];

  matrix_stream_loader #(.WIDTH(W), .ROWS(R), .COLS(C)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_matrix(out_matrix),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_last  (err_last)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: matrix under construction, queue of completed matrices (capacity two), sticky error.
  logic [N*W-1:0] cur;
  logic [N*W-1:0] q[$];
  int             k;
  bit             m_err;

  function automatic logic [W-1:0] elem(int i, logic [W-1:0] base);
    return W'(8'h10 * (i / C) + 8'h0A + (i % C)) + base;
  endfunction

  function automatic logic [N*W-1:0] dut_flat();
    logic [N*W-1:0] f;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        f[(r*C+c)*W +: W] = out_matrix[r][c];
    return f;
  endfunction

  task automatic check(string tag, logic [N*W-1:0] obs, logic [N*W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    check({tag, ".in_ready"}, in_ready, rst && (q.size() < 2));
    check({tag, ".out_valid"}, out_valid, q.size() > 0);
    check({tag, ".err_last"}, err_last, m_err);
    if (q.size() > 0) check({tag, ".matrix"}, dut_flat(), q[0]);
  endtask

  task automatic tick(bit v, logic [W-1:0] d, bit l, bit ordy, bit r_n, string tag);
    bit acc, rel;
    int row, col;
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = ordy;
    rst       = r_n;
    acc = v && (q.size() < 2);
    rel = ordy && (q.size() > 0);
    @(posedge clk);
    if (!r_n) begin
      cur = '0;
      q.delete();
      k = 0;
      m_err = 1'b0;
    end else begin
      if (rel) void'(q.pop_front());
      if (acc) begin
`ifdef LOADER_COLMAJOR_EN
        row = k % R;
        col = k / R;
`else
        row = k / C;
        col = k % C;
`endif
        cur[(row*C+col)*W +: W] = d;
        if (l != (k == N - 1)) m_err = 1'b1;
        if (k == N - 1) begin
          q.push_back(cur);
          k = 0;
        end else begin
          k++;
        end
      end
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    cur = '0;
    k = 0;
    m_err = 1'b0;

    repeat (3) tick(0, 8'h00, 0, 0, 0, "reset");
    check("reset.zero", dut_flat(), '0);
    tick(0, 8'h00, 0, 0, 1, "idle");
    check("idle.in_ready", in_ready, 1'b1);
    check("idle.zero", dut_flat(), '0);

    // Single matrix, no consumer.
    for (int i = 0; i < N; i++) tick(1, elem(i, 8'h00), i == N - 1, 0, 1, "single");
    check("single.valid", out_valid, 1'b1);
`ifdef LOADER_COLMAJOR_EN
    check("single.m23", out_matrix[2][3], 8'h3C);
`else
    check("single.m23", out_matrix[2][3], 8'h2D);
`endif
    check("single.m00", out_matrix[0][0], 8'h0A);
    check("single.err", err_last, 1'b0);

    // Second matrix fills the other bank; both banks then full.
    for (int i = 0; i < N; i++) tick(1, elem(i, 8'h40), i == N - 1, 0, 1, "fill2");
    check("bp.in_ready", in_ready, 1'b0);
    tick(1, 8'hEE, 0, 0, 1, "blocked");
    check("bp.m00", out_matrix[0][0], 8'h0A);
    tick(0, 8'h00, 0, 1, 1, "release1");
    check("bp.ready_back", in_ready, 1'b1);
    check("bp.second", out_matrix[0][0], 8'h4A);

    // Final write and release in the same cycle.
    for (int i = 0; i < N; i++) tick(1, elem(i, 8'h80), i == N - 1, i == N - 1, 1, "simul");
    check("simul.valid", out_valid, 1'b1);
    check("simul.m00", out_matrix[0][0], 8'h8A);
    tick(0, 8'h00, 0, 1, 1, "drain1");
    check("drain1.valid", out_valid, 1'b0);

    // Framing error on element 5.
    for (int i = 0; i < N; i++) begin
      tick(1, elem(i, 8'hC0), (i == 4) || (i == N - 1), 0, 1, "frame");
      if (i == 4) check("frame.err_set", err_last, 1'b1);
    end
    check("frame.valid", out_valid, 1'b1);
    tick(0, 8'h00, 0, 1, 1, "frame_rel");
    tick(0, 8'h00, 0, 0, 1, "frame_idle");
    check("frame.sticky", err_last, 1'b1);
    tick(0, 8'h00, 0, 0, 0, "frame_rst");
    check("frame.cleared", err_last, 1'b0);
    tick(0, 8'h00, 0, 0, 1, "frame_rel_rst");

    // Partial matrix discarded by reset.
    for (int i = 0; i < 7; i++) tick(1, elem(i, 8'h00), 0, 0, 1, "partial");
    tick(0, 8'h00, 0, 0, 0, "midrst");
    repeat (3) tick(0, 8'h00, 0, 0, 1, "post_rst");
    check("midrst.valid", out_valid, 1'b0);
    for (int i = 0; i < N; i++) tick(1, elem(i, 8'h00), i == N - 1, 0, 1, "fresh");
`ifdef LOADER_COLMAJOR_EN
    check("fresh.m10", out_matrix[1][0], 8'h0B);
`else
    check("fresh.m10", out_matrix[1][0], 8'h1A);
`endif
    tick(0, 8'h00, 0, 1, 1, "fresh_rel");

    // Random traffic with occasional framing errors and resets.
    for (int n = 0; n < 600; n++) begin
      tick(($urandom % 4) != 0, W'($urandom), (k == N - 1) ^ (($urandom % 32) == 0),
           ($urandom % 3) == 0, ($urandom % 150) != 0, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
